// File: rtl/mul_seq_ctrl_pkg.sv
// Shared definitions for the sequential shift-add multiplier.
// Holds the controller state encoding and the iteration-counter width helper
// used by mul_seq_ctrl and its datapath.
package mul_seq_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // The counter must hold the value WIDTH itself, hence one extra bit.
    function automatic int cnt_width(input int width);
        return $clog2(width) + 1;
    endfunction

    localparam int DEFAULT_WIDTH = 16;
    localparam int CNT_W         = cnt_width(DEFAULT_WIDTH);

endpackage

// File: rtl/mul_shift_add_dp.sv
// Radix-2 shift-add datapath: multiplicand, multiplier and accumulator
// registers plus the single shared adder.
// Ports:
//   clk, rst      clock and asynchronous active-high reset
//   clear         synchronous clear of all registers (abort)
//   load          capture op_a/op_b and zero the accumulator
//   step          perform one partial-product iteration
//   op_a, op_b    operands, only used when load=1
//   acc           accumulator including this cycle's partial product, i.e.
//                 the value the accumulator takes at the next step edge
//   mq_next_zero  the multiplier bits left after this step are all zero
import mul_seq_ctrl_pkg::*;

module mul_shift_add_dp #(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic                 load,
    input  logic                 step,
    input  logic [WIDTH-1:0]     op_a,
    input  logic [WIDTH-1:0]     op_b,
    output logic [2*WIDTH-1:0]   acc,
    output logic                 mq_next_zero
);

    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   mq_q, mq_d;
    logic [2*WIDTH-1:0] addend_s;
    logic [2*WIDTH-1:0] acc_sum_s;

    // Shared adder: add the multiplicand when the current multiplier LSB is set.
    always_comb begin
        addend_s     = {(2*WIDTH){1'b0}};
        if (mq_q[0]) begin
            addend_s = mcand_q;
        end else begin
            addend_s = {(2*WIDTH){1'b0}};
        end
        acc_sum_s    = acc_q + addend_s;
        mq_next_zero = ~|mq_q[WIDTH-1:1];
    end

    // Next-state selection for the datapath registers; clear wins over load/step.
    always_comb begin
        mcand_d = mcand_q;
        mq_d    = mq_q;
        acc_d   = acc_q;
        if (clear) begin
            mcand_d = {(2*WIDTH){1'b0}};
            mq_d    = {WIDTH{1'b0}};
            acc_d   = {(2*WIDTH){1'b0}};
        end else if (load) begin
            mcand_d = {{WIDTH{1'b0}}, op_a};
            mq_d    = op_b;
            acc_d   = {(2*WIDTH){1'b0}};
        end else if (step) begin
            mcand_d = {mcand_q[2*WIDTH-2:0], 1'b0};
            mq_d    = {1'b0, mq_q[WIDTH-1:1]};
            acc_d   = acc_sum_s;
        end else begin
            mcand_d = mcand_q;
            mq_d    = mq_q;
            acc_d   = acc_q;
        end
    end

    // Datapath register bank.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcand_q <= {(2*WIDTH){1'b0}};
            mq_q    <= {WIDTH{1'b0}};
            acc_q   <= {(2*WIDTH){1'b0}};
        end else begin
            mcand_q <= mcand_d;
            mq_q    <= mq_d;
            acc_q   <= acc_d;
        end
    end

    assign acc = acc_sum_s;

endmodule

// File: rtl/mul_seq_ctrl.sv
// Sequencing controller for an iterative unsigned WIDTH x WIDTH multiplier.
// One partial product per clock; the 2*WIDTH result is held until acknowledged.
// Ports:
//   clk, rst                 clock and asynchronous active-high reset
//   abort                    synchronous return to IDLE, clears result/iter_cnt
//   start_valid/start_ready  request handshake; ready only in IDLE
//   op_a, op_b               multiplicand / multiplier, sampled on acceptance
//   res_valid/res_ready      result handshake; valid only in DONE
//   result                   product, registered
//   busy                     high while iterating
//   iter_cnt                 iterations used by the last completed operation
import mul_seq_ctrl_pkg::*;

module mul_seq_ctrl #(
    parameter int WIDTH      = DEFAULT_WIDTH,
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        abort,
    input  logic                        start_valid,
    output logic                        start_ready,
    input  logic [WIDTH-1:0]            op_a,
    input  logic [WIDTH-1:0]            op_b,
    output logic                        res_valid,
    input  logic                        res_ready,
    output logic [2*WIDTH-1:0]          result,
    output logic                        busy,
    output logic [cnt_width(WIDTH)-1:0] iter_cnt
);

    localparam int             CW       = cnt_width(WIDTH);
    localparam logic [CW-1:0]  CNT_ONE  = CW'(1'b1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);

    state_e               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [CW-1:0]        iter_cnt_q, iter_cnt_d;
    logic [2*WIDTH-1:0]   result_q, result_d;
    logic                 load_s;
    logic                 step_s;
    logic                 last_iter_s;
    logic                 mq_next_zero_s;
    logic [2*WIDTH-1:0]   acc_s;

    mul_shift_add_dp #(.WIDTH(WIDTH)) u_dp (
        .clk          (clk),
        .rst          (rst),
        .clear        (abort),
        .load         (load_s),
        .step         (step_s),
        .op_a         (op_a),
        .op_b         (op_b),
        .acc          (acc_s),
        .mq_next_zero (mq_next_zero_s)
    );

    // The current step is the last one when the fixed count is reached or,
    // with early exit, no set multiplier bits remain after this shift.
    always_comb begin
        last_iter_s = (cnt_q == CNT_LAST) || (EARLY_EXIT && mq_next_zero_s);
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; abort overrides every transition.
    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_valid) state_d = ST_CALC;
                    else             state_d = ST_IDLE;
                end
                ST_CALC: begin
                    if (last_iter_s) state_d = ST_DONE;
                    else             state_d = ST_CALC;
                end
                // Acknowledge only; a coincident start waits for IDLE.
                ST_DONE: begin
                    if (res_ready) state_d = ST_IDLE;
                    else           state_d = ST_DONE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // State-decoded handshake outputs and datapath strobes.
    always_comb begin
        start_ready = 1'b0;
        res_valid   = 1'b0;
        busy        = 1'b0;
        case (state_q)
            ST_IDLE: start_ready = 1'b1;
            ST_CALC: busy        = 1'b1;
            ST_DONE: res_valid   = 1'b1;
            default: start_ready = 1'b0;
        endcase
        load_s = (state_q == ST_IDLE) && start_valid && !abort;
        step_s = (state_q == ST_CALC) && !abort;
    end

    // Iteration counter and captured result / iteration count.
    always_comb begin
        cnt_d      = cnt_q;
        result_d   = result_q;
        iter_cnt_d = iter_cnt_q;
        if (abort) begin
            cnt_d      = {CW{1'b0}};
            result_d   = {(2*WIDTH){1'b0}};
            iter_cnt_d = {CW{1'b0}};
        end else if (load_s) begin
            cnt_d      = {CW{1'b0}};
        end else if (step_s) begin
            cnt_d = cnt_q + CNT_ONE;
            if (last_iter_s) begin
                result_d   = acc_s;
                iter_cnt_d = cnt_q + CNT_ONE;
            end else begin
                result_d   = result_q;
                iter_cnt_d = iter_cnt_q;
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q      <= {CW{1'b0}};
            result_q   <= {(2*WIDTH){1'b0}};
            iter_cnt_q <= {CW{1'b0}};
        end else begin
            cnt_q      <= cnt_d;
            result_q   <= result_d;
            iter_cnt_q <= iter_cnt_d;
        end
    end

    assign result   = result_q;
    assign iter_cnt = iter_cnt_q;

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Scoreboard bench: two instances (EARLY_EXIT=0 and EARLY_EXIT=1) driven in
// turn; expected products and latencies are queued on acceptance and checked
// by a monitor when res_valid rises.
module tb_mul_seq_ctrl;

    typedef struct {
        logic [31:0] res;
        int          lat;
        int          e0;
    } exp_t;

    logic        clk = 1'b0;
    logic        rs[2];
    logic        ab[2];
    logic        sv[2];
    logic        sr[2];
    logic [15:0] oa[2];
    logic [15:0] ob[2];
    logic        rv[2];
    logic        rr[2];
    logic [31:0] res_o[2];
    logic        bz[2];
    logic [4:0]  it[2];
    logic        prev_v[2];

    exp_t q0[$];
    exp_t q1[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mul_seq_ctrl #(.WIDTH(16), .EARLY_EXIT(1'b0)) dut0 (
        .clk(clk), .rst(rs[0]), .abort(ab[0]), .start_valid(sv[0]), .start_ready(sr[0]),
        .op_a(oa[0]), .op_b(ob[0]), .res_valid(rv[0]), .res_ready(rr[0]),
        .result(res_o[0]), .busy(bz[0]), .iter_cnt(it[0])
    );

    mul_seq_ctrl #(.WIDTH(16), .EARLY_EXIT(1'b1)) dut1 (
        .clk(clk), .rst(rs[1]), .abort(ab[1]), .start_valid(sv[1]), .start_ready(sr[1]),
        .op_a(oa[1]), .op_b(ob[1]), .res_valid(rv[1]), .res_ready(rr[1]),
        .result(res_o[1]), .busy(bz[1]), .iter_cnt(it[1])
    );

    task automatic chk(input string nm, input int d, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d: got %0h, expected %0h at cycle %0d", nm, d, act, exp, cyc);
        end
    endtask

    // Reference model: full product, and iteration count from the multiplier's MSB.
    function automatic int exp_lat(input int d, input logic [15:0] b);
        int p;
        if (d == 0) return 16;
        if (b == 16'd0) return 1;
        p = 0;
        for (int i = 0; i < 16; i++) if (b[i]) p = i;
        return p + 1;
    endfunction

    task automatic push_exp(input int d, input logic [15:0] a, input logic [15:0] b);
        exp_t e;
        e.res = 32'(a) * 32'(b);
        e.lat = exp_lat(d, b);
        e.e0  = cyc + 1;
        if (d == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    task automatic flush(input int d);
        if (d == 0) q0.delete();
        else        q1.delete();
    endtask

    // Called at a negedge; returns at the negedge after the acceptance edge.
    task automatic issue(input int d, input logic [15:0] a, input logic [15:0] b);
        int n;
        sv[d] = 1'b1; oa[d] = a; ob[d] = b;
        n = 0;
        while (!sr[d] && n < 50) begin @(negedge clk); n++; end
        if (!sr[d]) begin
            checks++; errors++;
            $display("FAIL accept_timeout dut%0d: start_ready still 0 after %0d cycles", d, n);
        end else begin
            push_exp(d, a, b);
        end
        @(negedge clk);
        sv[d] = 1'b0; oa[d] = 16'($urandom); ob[d] = 16'($urandom);
    endtask

    task automatic wait_valid(input int d);
        int n;
        n = 0;
        while (!rv[d] && n < 60) begin @(negedge clk); n++; end
        if (!rv[d]) begin
            checks++; errors++;
            $display("FAIL result_timeout dut%0d: res_valid still 0 after %0d cycles", d, n);
        end
    endtask

    task automatic ack(input int d);
        rr[d] = 1'b1;
        @(negedge clk);
        rr[d] = 1'b0;
    endtask

    // Full operation with `hold` cycles of backpressure while a competing
    // request is presented.
    task automatic run_op(input int d, input logic [15:0] a, input logic [15:0] b, input int hold);
        logic [31:0] prod;
        prod = 32'(a) * 32'(b);
        issue(d, a, b);
        wait_valid(d);
        for (int i = 0; i < hold; i++) begin
            sv[d] = 1'b1; oa[d] = 16'($urandom); ob[d] = 16'($urandom);
            chk("hold_result", d, 64'(res_o[d]), 64'(prod));
            chk("hold_valid", d, 64'(rv[d]), 64'd1);
            chk("hold_ready", d, 64'(sr[d]), 64'd0);
            @(negedge clk);
        end
        sv[d] = 1'b0;
        ack(d);
        chk("ack_valid_low", d, 64'(rv[d]), 64'd0);
    endtask

    // Monitor: pop the oldest expectation whenever a result is presented.
    always @(negedge clk) begin
        exp_t e;
        for (int d = 0; d < 2; d++) begin
            if (rv[d] && !prev_v[d]) begin
                if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
                    checks++; errors++;
                    $display("FAIL unexpected_result dut%0d: got result %0h, expected no result", d, res_o[d]);
                end else begin
                    if (d == 0) e = q0.pop_front();
                    else        e = q1.pop_front();
                    chk("result", d, 64'(res_o[d]), 64'(e.res));
                    chk("iter_cnt", d, 64'(it[d]), 64'(e.lat));
                    chk("latency", d, 64'(cyc - e.e0), 64'(e.lat));
                end
            end
            prev_v[d] <= rv[d];
        end
    end

    task automatic reset_checks(input int d);
        chk("rst_start_ready", d, 64'(sr[d]), 64'd1);
        chk("rst_res_valid", d, 64'(rv[d]), 64'd0);
        chk("rst_busy", d, 64'(bz[d]), 64'd0);
        chk("rst_result", d, 64'(res_o[d]), 64'd0);
        chk("rst_iter_cnt", d, 64'(it[d]), 64'd0);
    endtask

    initial begin
        logic [15:0] ra, rb;
        for (int d = 0; d < 2; d++) begin
            rs[d] = 1'b1; ab[d] = 1'b0; sv[d] = 1'b0; rr[d] = 1'b0;
            oa[d] = 16'd0; ob[d] = 16'd0; prev_v[d] = 1'b0;
        end
        repeat (2) @(negedge clk);
        reset_checks(0);
        reset_checks(1);
        rs[0] = 1'b0; rs[1] = 1'b0;
        @(negedge clk);

        // ---- EARLY_EXIT = 0 ----
        run_op(0, 16'd3, 16'd5, 10);
        run_op(0, 16'hFFFF, 16'hFFFF, 0);
        // acknowledge and new request together: start waits one edge
        issue(0, 16'd11, 16'd13);
        wait_valid(0);
        rr[0] = 1'b1; sv[0] = 1'b1; oa[0] = 16'd17; ob[0] = 16'd19;
        @(negedge clk);
        rr[0] = 1'b0;
        chk("bubble_ready", 0, 64'(sr[0]), 64'd1);
        chk("bubble_valid", 0, 64'(rv[0]), 64'd0);
        push_exp(0, 16'd17, 16'd19);
        @(negedge clk);
        sv[0] = 1'b0;
        chk("chain_busy", 0, 64'(bz[0]), 64'd1);
        wait_valid(0);
        ack(0);
        // abort at iteration 5
        issue(0, 16'd100, 16'd200);
        repeat (3) @(negedge clk);
        ab[0] = 1'b1;
        @(negedge clk);
        ab[0] = 1'b0;
        flush(0);
        reset_checks(0);
        run_op(0, 16'd2, 16'd3, 0);
        for (int i = 0; i < 12; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom) >> $urandom_range(0, 15);
            run_op(0, ra, rb, $urandom_range(0, 3));
        end

        // ---- EARLY_EXIT = 1 ----
        run_op(1, 16'h1234, 16'h0000, 0);
        run_op(1, 16'd7, 16'h0004, 2);
        run_op(1, 16'hFFFF, 16'hFFFF, 0);
        // asynchronous reset between edges mid-calculation
        issue(1, 16'h0ABC, 16'hF00F);
        @(posedge clk);
        #2 rs[1] = 1'b1;
        #1 reset_checks(1);
        flush(1);
        @(negedge clk);
        rs[1] = 1'b0;
        @(negedge clk);
        run_op(1, 16'd9, 16'd9, 0);
        for (int i = 0; i < 12; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom) >> $urandom_range(0, 15);
            run_op(1, ra, rb, $urandom_range(0, 3));
        end

        repeat (3) @(negedge clk);
        chk("q0_drained", 0, 64'(q0.size()), 64'd0);
        chk("q1_drained", 1, 64'(q1.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mul_seq_ctrl.md
Name: mul_seq_ctrl

Overview:
- Sequencing controller and iterative radix-2 shift-add engine for unsigned WIDTH x WIDTH multiplication.
- Sits between the operand-entry/button logic and the seven-segment display path.
- Accepts an operation through a valid/ready handshake, runs one partial-product step per clock, and presents a 2*WIDTH result that is held until acknowledged.
- Replaces the free-running combinational multiplier with a start/done-controlled unit that shares one adder across cycles.

Parameters:
- WIDTH, 16: operand width in bits; result is 2*WIDTH.
- EARLY_EXIT, 1: when 1, the computation ends as soon as the remaining multiplier bits are all zero. When 0, it always runs exactly WIDTH iterations.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- abort  input  1  synchronous clear; returns the block to IDLE from any state.
- start_valid  input  1  an operation request is present on op_a/op_b.
- start_ready  output  1  the block can accept a request; high only in IDLE.
- op_a  input  WIDTH  multiplicand, sampled on acceptance.
- op_b  input  WIDTH  multiplier, sampled on acceptance.
- res_valid  output  1  result is valid; high only in DONE.
- res_ready  input  1  consumer acknowledges the result.
- result  output  2*WIDTH  product; stable while res_valid=1.
- busy  output  1  high in CALC.
- iter_cnt  output  $clog2(WIDTH)+1  iterations used by the last completed operation.

Behaviour:
- Reset (async, rst=1): state=IDLE; start_ready=1; res_valid=0; busy=0; result=0; iter_cnt=0; internal mcand, mq, acc and cnt all 0.
- States: IDLE, CALC, DONE.
- IDLE:
  - start_ready=1.
  - Acceptance happens at edge E0 when start_valid=1.
  - At E0: mcand <= {WIDTH'b0, op_a}; mq <= op_b; acc <= 0; cnt <= 0; state -> CALC.
  - op_a/op_b are ignored at all other times.
- CALC, one iteration per edge:
  - If mq[0]=1, acc <= acc + mcand (2*WIDTH-bit add, never overflows).
  - mcand <= mcand << 1; mq <= mq >> 1; cnt <= cnt + 1.
  - Go to DONE on the same edge when cnt == WIDTH-1, or when EARLY_EXIT=1 and (mq >> 1) == 0.
  - On that edge: result <= final acc; iter_cnt <= cnt + 1.
- Latency with EARLY_EXIT=0: res_valid rises exactly WIDTH edges after E0.
- Latency with EARLY_EXIT=1: res_valid rises max(1, p+1) edges after E0, where p is the bit index of the MSB set in op_b.
  - op_b=0 gives 1 iteration with result 0.
- DONE:
  - res_valid=1; result and iter_cnt held stable.
  - When res_ready=1 at an edge: state -> IDLE, and res_valid falls after that edge.
  - res_ready asserted in any other state is ignored.
- Simultaneous res_ready and start_valid in DONE: only the acknowledge is taken. The start is accepted at the next edge, giving a minimum 1-cycle bubble between operations.
- start_valid while in CALC or DONE: not accepted, because start_ready=0. The requester must hold the request.
- abort=1 at an edge:
  - Any state -> IDLE; result=0; iter_cnt=0; acc=0; res_valid=0.
  - abort has priority over acceptance, iteration and acknowledge.
- rst asserted mid-CALC: immediate return to the reset values above. No partial result is exposed.
- Outputs are registered or decoded from state only; there are no combinational paths from inputs to outputs.

Decomposition:
- Shared package holds:
  - State encoding: ST_IDLE=2'd0, ST_CALC=2'd1, ST_DONE=2'd2.
  - Count-width helper constant CNT_W = $clog2(WIDTH)+1.
- One sub-module: mul_shift_add_dp.
  - Contains the mcand/mq/acc registers and the adder.
  - Controlled by load and step strobes from the FSM.
  - Exports mq_next_zero and acc.
- The FSM, counter and handshake logic stay in mul_seq_ctrl.

Test Plan:
- Basic, EARLY_EXIT=0: op_a=3, op_b=5 accepted at E0 -> res_valid=1 exactly 16 edges later; result=32'd15; iter_cnt=16.
- Full scale: op_a=16'hFFFF, op_b=16'hFFFF -> result=32'hFFFE0001; iter_cnt=16 for both EARLY_EXIT=0 and EARLY_EXIT=1.
- Early exit, EARLY_EXIT=1:
  - op_b=0, op_a=16'h1234 -> res_valid 1 edge after E0; result=0; iter_cnt=1.
  - op_b=16'h0004, op_a=7 -> res_valid after 3 edges; result=28.
- Backpressure:
  - Hold res_ready=0 for 10 cycles in DONE -> result and res_valid stable throughout; start_ready=0; a new start_valid is not accepted.
  - Assert res_ready together with start_valid -> the new operation is accepted one edge later.
- Abort: assert abort for 1 cycle at iteration 5 of op_a=100, op_b=200 -> next cycle IDLE, start_ready=1, result=0; a following 2*3 operation yields 6.
- Async reset: pulse rst between clock edges during CALC -> outputs return to reset values immediately, without waiting for a clock edge; after release, 9*9 yields 81.
